// File: rtl/uart_frame_scheduler.sv
// Round-robin arbiter that frames one producer word at a time and feeds the bytes to the UART.
// Define UART_FRAME_CHECKSUM_EN to append an XOR checksum byte (5-byte frame instead of 4).
module uart_frame_scheduler #(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [7:0]             uart_data,
  output logic                   uart_data_rdy,
  input  logic                   uart_tx_busy,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  state_t               state_q;
  logic [2:0]           rr_ptr_q;
  logic [2:0]           id_q;
  logic [15:0]          word_q;
  logic [2:0]           byte_idx_q;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic [7:0]           uart_data_q;
  logic                 uart_data_rdy_q;
  logic [15:0]          frame_cnt_q;
  logic [15:0]          frame_cnt_d;

  logic                 grant_vld;
  logic [2:0]           grant_idx;
  logic [3:0]           cand;
  logic [7:0]           req_pad;
  logic [15:0]          grant_word;
  logic [NUM_REQ-1:0]   grant_oh;

  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [2:0]  id,
                                            input logic [15:0] w);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {5'b0, id};
      3'd2:    b = w[15:8];
      3'd3:    b = w[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
      default: b = {5'b0, id} ^ w[15:8] ^ w[7:0];
`else
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

  // Search starts one past the last winner, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_pad   = 8'(req);
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(NUM_REQ))
        cand = cand - 4'(NUM_REQ);
      if (!grant_vld && req_pad[cand[2:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    grant_word = '0;
    grant_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) begin
        grant_word  = req_data[16*i +: 16];
        grant_oh[i] = grant_vld;
      end
    end
  end

  assign frame_cnt_d = frame_cnt_q + 16'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= 3'(NUM_REQ - 1);
      id_q            <= '0;
      word_q          <= '0;
      byte_idx_q      <= '0;
      req_ack_q       <= '0;
      uart_data_q     <= '0;
      uart_data_rdy_q <= 1'b0;
      frame_cnt_q     <= '0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            req_ack_q       <= grant_oh;
            rr_ptr_q        <= grant_idx;
            id_q            <= grant_idx;
            word_q          <= grant_word;
            byte_idx_q      <= '0;
            uart_data_q     <= frame_byte(3'd0, grant_idx, grant_word);
            uart_data_rdy_q <= 1'b1;
            state_q         <= LOAD;
          end
        end
        // busy seen high means the UART has taken the byte; drop rdy so it cannot relaunch.
        LOAD: begin
          if (uart_tx_busy) begin
            uart_data_rdy_q <= 1'b0;
            state_q         <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (byte_idx_q == LAST_IDX) begin
              frame_cnt_q <= frame_cnt_d;
              uart_data_q <= '0;
              state_q     <= IDLE;
            end else begin
              byte_idx_q      <= byte_idx_q + 3'd1;
              uart_data_q     <= frame_byte(byte_idx_q + 3'd1, id_q, word_q);
              uart_data_rdy_q <= 1'b1;
              state_q         <= LOAD;
            end
          end
        end
        default: begin
          uart_data_rdy_q <= 1'b0;
          state_q         <= IDLE;
        end
      endcase
    end
  end

  assign req_ack       = req_ack_q;
  assign uart_data     = uart_data_q;
  assign uart_data_rdy = uart_data_rdy_q;
  assign busy          = (state_q != IDLE);
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a behavioural UART handshake model.
module tb_uart_frame_scheduler;

  localparam int NR       = 4;
  localparam int BUSY_CYC = 3;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NR-1:0]        req = '0;
  logic [16*NR-1:0]     req_data = '0;
  logic [NR-1:0]        req_ack;
  logic [7:0]           uart_data;
  logic                 uart_data_rdy;
  logic                 uart_tx_busy;
  logic                 busy;
  logic [15:0]          frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  int         ack_q[$];
  int         multi_ack = 0;
  int         bcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  uart_frame_scheduler #(.NUM_REQ(NR), .SYNC_BYTE(8'hA5)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req           (req),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .uart_data     (uart_data),
    .uart_data_rdy (uart_data_rdy),
    .uart_tx_busy  (uart_tx_busy),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 clock = ~clock;

  // UART model: accepts a byte when idle and data_rdy, then stays busy BUSY_CYC cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uart_tx_busy <= 1'b0;
      bcnt         <= 0;
    end else if (uart_tx_busy) begin
      if (bcnt == 1) uart_tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (uart_data_rdy) begin
      uart_tx_busy <= 1'b1;
      bcnt         <= BUSY_CYC;
      rx_q.push_back(uart_data);
    end
  end

  always @(negedge clock) begin
    if (reset_n && req_ack != '0) begin
      if ($onehot(req_ack)) begin
        for (int i = 0; i < NR; i++)
          if (req_ack[i]) ack_q.push_back(i);
      end else begin
        multi_ack++;
      end
    end
  end

  task automatic wait_ack(output logic [NR-1:0] a);
    a = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (req_ack != '0) begin
        a = req_ack;
        break;
      end
    end
    chk("wait_ack_expired", (a != '0), 1'b1);
  endtask

  task automatic wait_cnt(input logic [15:0] target, input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (!busy && frame_cnt == target) break;
    end
    chk({tag, "_cnt"}, frame_cnt, target);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_frame(input int base, input logic [2:0] id,
                             input logic [15:0] w, input string tag);
    logic [7:0] e [5];
    e[0] = 8'hA5;
    e[1] = {5'b0, id};
    e[2] = w[15:8];
    e[3] = w[7:0];
    e[4] = {5'b0, id} ^ w[15:8] ^ w[7:0];
    for (int k = 0; k < FLEN; k++)
      chk($sformatf("%s_b%0d", tag, k), rx_q[base + k], e[k]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rx_q.delete();
    ack_q.delete();
    @(negedge clock);
  endtask

  initial begin
    logic [NR-1:0] a;
    int n;
    logic [15:0] w [4];

    // Reset state
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_rdy", uart_data_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", req_ack, 4'b0000);
    chk("rst_cnt", frame_cnt, 16'h0000);

    // Single request from id 2
    req_data[2*16 +: 16] = 16'h1234;
    req = 4'b0100;
    wait_ack(a);
    req = '0;
    chk("t2_ack", a, 4'b0100);
    chk("t2_rdy_latency", uart_data_rdy, 1'b1);
    chk("t2_first_byte", uart_data, 8'hA5);
    chk("t2_busy", busy, 1'b1);
    @(negedge clock);
    chk("t2_ack_pulse", req_ack, 4'b0000);
    wait_cnt(16'd1, "t2");
    chk("t2_nbytes", rx_q.size(), FLEN);
    check_frame(0, 3'd2, 16'h1234, "t2");
    chk("t2_nacks", ack_q.size(), 1);

    // All requesters held high: round robin from a fresh pointer
    do_reset();
    w[0] = 16'h0F0F; w[1] = 16'h1357; w[2] = 16'hBEEF; w[3] = 16'h8001;
    for (int i = 0; i < NR; i++) req_data[16*i +: 16] = w[i];
    req = 4'b1111;
    n = 0;
    for (int i = 0; i < 2000 && n < 5; i++) begin
      @(negedge clock);
      if (req_ack != '0) n++;
    end
    req = '0;
    wait_cnt(16'd5, "t3");
    chk("t3_nacks", ack_q.size(), 5);
    chk("t3_nbytes", rx_q.size(), 5 * FLEN);
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("t3_order%0d", f), ack_q[f], f % NR);
      check_frame(f * FLEN, 3'(f % NR), w[f % NR], $sformatf("t3_f%0d", f));
    end

    // Requests raised while a frame is in flight
    rx_q.delete();
    ack_q.delete();
    req = 4'b0001;
    wait_ack(a);
    chk("t4_ack0", a, 4'b0001);
    req = 4'b1010;
    n = 0;
    for (int i = 0; i < 2000 && n < 2; i++) begin
      @(negedge clock);
      if (req_ack != '0) begin
        n++;
        req = req & ~req_ack;
      end
    end
    req = '0;
    wait_cnt(16'd8, "t4");
    chk("t4_nacks", ack_q.size(), 3);
    chk("t4_g1", ack_q[1], 1);
    chk("t4_g2", ack_q[2], 3);
    chk("t4_nbytes", rx_q.size(), 3 * FLEN);
    check_frame(0, 3'd0, w[0], "t4_f0");
    check_frame(FLEN, 3'd1, w[1], "t4_f1");
    check_frame(2 * FLEN, 3'd3, w[3], "t4_f2");

    // Reset in the middle of a frame
    rx_q.delete();
    ack_q.delete();
    req_data[2*16 +: 16] = 16'hC3D2;
    req = 4'b0100;
    wait_ack(a);
    req = '0;
    for (int i = 0; i < 200 && rx_q.size() < 2; i++) @(negedge clock);
    chk("t5_pre_bytes", rx_q.size(), 2);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_rdy", uart_data_rdy, 1'b0);
    chk("t5_cnt", frame_cnt, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("t5_no_resend", rx_q.size(), 2);
    chk("t5_idle_rdy", uart_data_rdy, 1'b0);
    rx_q.delete();
    ack_q.delete();
    req_data[1*16 +: 16] = 16'h5AA5;
    req = 4'b0010;
    wait_ack(a);
    req = '0;
    chk("t5_ack", a, 4'b0010);
    wait_cnt(16'd1, "t5");
    chk("t5_nbytes", rx_q.size(), FLEN);
    check_frame(0, 3'd1, 16'h5AA5, "t5");

    // frame_cnt wrap
    rx_q.delete();
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_cnt_q;
    @(negedge clock);
    chk("t6_preload", frame_cnt, 16'hFFFF);
    req_data[3*16 +: 16] = 16'h7E81;
    req = 4'b1000;
    wait_ack(a);
    req = '0;
    wait_cnt(16'h0000, "t6");
    chk("t6_nbytes", rx_q.size(), FLEN);
    check_frame(0, 3'd3, 16'h7E81, "t6");

    chk("multi_hot_ack", multi_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
